// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end.
// Keeps the program counter and issues one sequential word request per cycle
// to a synchronous instruction memory. Returned words are stored with their
// PCs in a DEPTH-entry FIFO, which decode drains over a valid/ready handshake.
// A redirect flushes everything and restarts fetch at the new PC.
//
// Optional build macro:
//   FETCH_PERF_EN - adds perf_starve_cnt, a free-running count of cycles in
//                   which decode had nothing to consume (instr_valid low).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_starve_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Credit comparison needs one spare bit so count + inflight cannot wrap.
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [31:0]      fifo_instr [DEPTH];
  logic [31:0]      fifo_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W:0]   credit_used;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_pc_aligned;

  // Entries already stored plus the one response still on its way back.
  // A pop in this cycle deliberately does not free a credit until next cycle.
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Redirect cancels both the write of the arriving response and any pop.
  assign push = inflight & ~redirect;
  assign pop  = instr_valid & instr_ready & ~redirect;

  assign imem_req  = rstn & ~redirect & (credit_used < DEPTH_C);
  assign imem_addr = pc;

  assign instr_valid = (count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];

  // PC and in-flight tracking: advance on each issued request, jump on redirect.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc          <= redirect_pc_aligned;
      inflight    <= 1'b0;
    end else if (imem_req) begin
      pc          <= pc + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue outright.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero until filled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= inflight_pc;
    end
  end

`ifdef FETCH_PERF_EN
  // Starvation counter: cycles out of reset with nothing for decode.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_starve_cnt <= '0;
    end else if (!instr_valid) begin
      perf_starve_cnt <= perf_starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end that produces the 32-bit instruction word consumed by the decode stage. Holds the program counter, issues sequential word requests to a synchronous instruction memory, buffers returned words with their PCs in a small FIFO, and presents them to decode through a valid/ready handshake. A redirect from branch resolution flushes the queue and restarts fetch at a new PC.

## Interface

Parameters:
- DEPTH, 4, FIFO entries (power of two, 2..16).
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, synchronous, active-low.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  32  byte address of request; equals internal pc.
- imem_rdata  input  32  read data, valid exactly one cycle after an accepted imem_req.
- instr  output  32  instruction word at queue head (feeds decode instr).
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  queue non-empty.
- instr_ready  input  1  decode accepts head this cycle.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  32  new PC; word-aligned, bits [1:0] ignored and treated as 0.
- perf_starve_cnt  output  32  present only with FETCH_PERF_EN (see Configuration).

## Operation

- State: pc (32), inflight (1 bit), inflight_pc (32), FIFO of DEPTH x {instr, pc}, rd_ptr/wr_ptr (log2 DEPTH), count (0..DEPTH).
- Request: imem_req = rstn & ~redirect & (count + inflight < DEPTH). Memory always accepts. On request, pc <= pc + 4 (wraps modulo 2^32), inflight <= 1, inflight_pc <= pc; otherwise inflight <= 0.
- Response: when inflight = 1 and no redirect this cycle, {imem_rdata, inflight_pc} is written at wr_ptr at the clock edge.
- Credit rule guarantees no overflow; pop does not return a credit in the same cycle.
- Pop: instr_valid & instr_ready advances rd_ptr. Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).
- Redirect (highest priority): at the edge, count <= 0, rd_ptr <= wr_ptr <= 0, inflight <= 0 (in-flight response arriving next cycle is dropped), pc <= {redirect_pc[31:2], 2'b00}. Any push or pop in the same cycle is cancelled. Back-to-back redirects: last one wins.
- instr/instr_pc are driven from FIFO head registers; values are don't-care when instr_valid = 0.

## Timing

- Reset values: pc = RESET_PC, count = 0, pointers = 0, inflight = 0, instr_valid = 0, imem_req = 0 during the reset cycle, instr = 0, instr_pc = 0 when empty after reset, perf_starve_cnt = 0.
- Reset mid-operation discards FIFO contents and any in-flight response.
- Fetch latency: imem_req in cycle N -> data written at end of N+1 -> instr_valid in N+2.
- Steady state with instr_ready held high: one instruction per cycle after 2-cycle fill.
- Redirect in cycle R: imem_req = 0 in R; instr_valid = 0 in R+1; imem_req at redirect_pc in R+1; first redirected instruction valid in R+3.
- Backpressure: with instr_ready = 0, requests stop once count + inflight = DEPTH; queue holds DEPTH entries with no loss or duplication.

## Configuration

- FETCH_PERF_EN defined: perf_starve_cnt port exists; 32-bit counter increments every cycle where rstn = 1 and instr_valid = 0 (including post-redirect bubbles); wraps at 2^32; cleared only by reset.
- FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.

## Test plan

- Reset then instr_ready = 1, memory returns word = addr ^ 32'hA5A5_0000: imem_addr 0,4,8,... one per cycle; instr_valid first high 2 cycles after reset release; instr_pc 0,4,8 with matching words.
- instr_ready = 0 for 10 cycles, DEPTH = 4: exactly 4 requests issued (addr 0..12), count = 4, imem_req low; releasing ready drains 0,4,8,12 in order, fetch resumes at 16.
- Redirect to 32'h0000_0103 while queue holds 3 entries and a response is in flight: instr_valid 0 next cycle, next imem_addr 32'h0000_0100, dropped response never appears, first delivered instr_pc = 32'h100.
- Redirect asserted together with instr_ready and a valid head: pop cancelled, FIFO empty; redirects in two consecutive cycles to 0x200 then 0x300: first delivered instr_pc = 0x300.
- pc at 32'hFFFF_FFF8, ready high: instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- With FETCH_PERF_EN: after reset, ready high, no redirect, perf_starve_cnt = 2 and stays 2; one redirect adds exactly 2 more; rstn low mid-run clears it to 0.
